// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 device-to-host receiver with clock deglitch, frame check and DAV handshake
module ps2_scan_rx #(
  parameter logic [7:0]  FILTER_LEN = 8'd8,
  parameter logic [15:0] TIMEOUT    = 16'd25000
) (
  input  logic       mclk,
  input  logic       reset_in,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       do_read,
  output logic [7:0] scan_code,
  output logic       scan_dav,
  output logic       scan_err
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t      state_q, state_d;
  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_f_q, clk_f_d, clk_fd_q;
  logic [7:0]  flt_q, flt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] to_q, to_d;
  logic [7:0]  code_q, code_d;
  logic        dav_q, dav_d, err_q, err_d;
  logic        clk_s, data_s, fall, valid;
  assign clk_s     = clk_sync_q[1];
  assign data_s    = data_sync_q[1];
  assign fall      = clk_fd_q & ~clk_f_q;
  assign scan_code = code_q;
  assign scan_dav  = dav_q;
  assign scan_err  = err_q;
  always_comb begin
    flt_d   = 8'd0;
    clk_f_d = clk_f_q;
    if (clk_s != clk_f_q) begin
      if (flt_q + 8'd1 == FILTER_LEN) clk_f_d = clk_s;
      else flt_d = flt_q + 8'd1;
    end
  end
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    code_d   = code_q;
    dav_d    = dav_q & ~do_read;
    err_d    = 1'b0;
    to_d     = (state_q == IDLE) ? 16'd0 : to_q + 16'd1;
    valid    = data_s & (^shift_q ^ par_q);
    if (fall) begin
      to_d = 16'd0;
      case (state_q)
        IDLE: if (!data_s) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
        DATA: begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (valid && (!dav_q || do_read)) begin
            code_d = shift_q;
            dav_d  = 1'b1;
          end else err_d = 1'b1;
        end
      endcase
    end else if (state_q != IDLE && to_q + 16'd1 == TIMEOUT) begin
      // a fall in the same cycle wins, so the timeout sits in the else branch
      state_d = IDLE;
      to_d    = 16'd0;
      err_d   = 1'b1;
    end
  end
  always_ff @(posedge mclk or posedge reset_in) begin
    if (reset_in) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_f_q     <= 1'b1;
      clk_fd_q    <= 1'b1;
      flt_q       <= 8'd0;
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      to_q        <= 16'd0;
      code_q      <= 8'd0;
      dav_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_f_q     <= clk_f_d;
      clk_fd_q    <= clk_f_q;
      flt_q       <= flt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_q        <= to_d;
      code_q      <= code_d;
      dav_q       <= dav_d;
      err_q       <= err_d;
    end
  end
endmodule
